alu_cmd_driver: RTL and testbench

Initiator-side front end for the 16-bit ALU (io_a/io_b/io_aluOp in, io_result out).
- Accepts tagged commands on a valid/ready port and drives the ALU operand/opcode inputs.
- Tracks each in-flight operation through the ALU's fixed latency and buffers results in a response FIFO with credit-based backpressure.
- Sits between the sequencer/decoder and the ALU instance.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_rsp_fifo.sv | 63 ++++++
 rtl/alu_cmd_driver.sv | 181 ++++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath width and a reference
// result model used by the optional self-check path.
package alu_pkg;

    localparam int ALU_W = 16;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;
    localparam logic [2:0] ALU_LD  = 3'd6;
    localparam logic [2:0] ALU_SHR = 3'd7;

    function automatic logic [ALU_W-1:0] alu_model(
        input logic [2:0]       op,
        input logic [ALU_W-1:0] a,
        input logic [ALU_W-1:0] b
    );
        logic [ALU_W-1:0] r;
        r = a;
        case (op)
            ALU_NOP: r = a;
            ALU_ADD: r = a + b;
            ALU_SUB: r = a - b;
            ALU_AND: r = a & b;
            ALU_OR:  r = a | b;
            ALU_XOR: r = a ^ b;
            ALU_LD:  r = b;
            ALU_SHR: r = a >> 1;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Synchronous response FIFO with occupancy count; DEPTH must be a power of two
// so the pointers wrap naturally.
module alu_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 20
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic                       valid_o,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem_q;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    do_pop;
    logic                    full;

    assign full   = (cnt_q == CW'(DEPTH));
    assign do_pop = pop_i && (cnt_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    // Upstream credit accounting must make this impossible.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full));

endmodule

// File: rtl/alu_cmd_driver.sv
// Initiator front end for the 16-bit ALU: issue register, latency tracking pipe
// and credit-guarded response FIFO. Define ALU_SELFCHECK_EN to add io_err/io_err_tag.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int ALU_LAT   = 1,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_cmd_valid,
    output logic             io_cmd_ready,
    input  logic [2:0]       io_cmd_op,
    input  logic [ALU_W-1:0] io_cmd_a,
    input  logic [ALU_W-1:0] io_cmd_b,
    input  logic [TAG_W-1:0] io_cmd_tag,
    output logic [ALU_W-1:0] io_alu_a,
    output logic [ALU_W-1:0] io_alu_b,
    output logic [2:0]       io_alu_aluOp,
    input  logic [ALU_W-1:0] io_alu_result,
    output logic             io_rsp_valid,
    input  logic             io_rsp_ready,
    output logic [ALU_W-1:0] io_rsp_result,
    output logic [TAG_W-1:0] io_rsp_tag,
`ifdef ALU_SELFCHECK_EN
    output logic             io_err,
    output logic [TAG_W-1:0] io_err_tag,
`endif
    output logic             io_busy
);
    localparam int CW = $clog2(RSP_DEPTH) + 1;
    localparam int FW = ALU_W + TAG_W;

    logic             accept;
    logic             iss_vld_q;
    logic [2:0]       iss_op_q;
    logic [ALU_W-1:0] iss_a_q, iss_b_q;
    logic [TAG_W-1:0] iss_tag_q;

    logic             tail_vld;
    logic [TAG_W-1:0] tail_tag;
    logic [2:0]       pipe_cnt;

    logic [FW-1:0]    fifo_din, fifo_dout;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_vld;
    logic [5:0]       used;

`ifdef ALU_SELFCHECK_EN
    logic [ALU_W-1:0] iss_exp_q;
    logic [ALU_W-1:0] tail_exp;
`endif

    assign accept = io_cmd_valid && io_cmd_ready;

    // Opcode drops back to NOP whenever nothing was accepted; operands hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            iss_vld_q <= 1'b0;
            iss_op_q  <= ALU_NOP;
            iss_a_q   <= '0;
            iss_b_q   <= '0;
            iss_tag_q <= '0;
        end else begin
            iss_vld_q <= accept;
            iss_op_q  <= accept ? io_cmd_op : ALU_NOP;
            if (accept) begin
                iss_a_q   <= io_cmd_a;
                iss_b_q   <= io_cmd_b;
                iss_tag_q <= io_cmd_tag;
            end
        end
    end

`ifdef ALU_SELFCHECK_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)      iss_exp_q <= '0;
        else if (accept) iss_exp_q <= alu_model(io_cmd_op, io_cmd_a, io_cmd_b);
    end
`endif

    assign io_alu_a     = iss_a_q;
    assign io_alu_b     = iss_b_q;
    assign io_alu_aluOp = iss_op_q;

    // Tracking pipe: tail lines up with the cycle io_alu_result is valid.
    if (ALU_LAT == 0) begin : g_nopipe
        assign tail_vld = iss_vld_q;
        assign tail_tag = iss_tag_q;
        assign pipe_cnt = '0;
`ifdef ALU_SELFCHECK_EN
        assign tail_exp = iss_exp_q;
`endif
    end else begin : g_pipe
        logic [ALU_LAT-1:0]            vld_pipe_q;
        logic [ALU_LAT-1:0][TAG_W-1:0] tag_pipe_q;
`ifdef ALU_SELFCHECK_EN
        logic [ALU_LAT-1:0][ALU_W-1:0] exp_pipe_q;
`endif

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                vld_pipe_q <= '0;
                tag_pipe_q <= '0;
`ifdef ALU_SELFCHECK_EN
                exp_pipe_q <= '0;
`endif
            end else begin
                vld_pipe_q[0] <= iss_vld_q;
                tag_pipe_q[0] <= iss_tag_q;
`ifdef ALU_SELFCHECK_EN
                exp_pipe_q[0] <= iss_exp_q;
`endif
                for (int k = 1; k < ALU_LAT; k++) begin
                    vld_pipe_q[k] <= vld_pipe_q[k-1];
                    tag_pipe_q[k] <= tag_pipe_q[k-1];
`ifdef ALU_SELFCHECK_EN
                    exp_pipe_q[k] <= exp_pipe_q[k-1];
`endif
                end
            end
        end

        always_comb begin
            pipe_cnt = '0;
            for (int k = 0; k < ALU_LAT; k++) pipe_cnt = pipe_cnt + 3'(vld_pipe_q[k]);
        end

        assign tail_vld = vld_pipe_q[ALU_LAT-1];
        assign tail_tag = tag_pipe_q[ALU_LAT-1];
`ifdef ALU_SELFCHECK_EN
        assign tail_exp = exp_pipe_q[ALU_LAT-1];
`endif
    end

    assign fifo_din = {io_alu_result, tail_tag};

    alu_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (FW)
    ) u_rsp_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (tail_vld),
        .data_i  (fifo_din),
        .pop_i   (io_rsp_ready),
        .valid_o (fifo_vld),
        .data_o  (fifo_dout),
        .count_o (fifo_cnt)
    );

    // Credits from registered state only: a same-cycle pop frees space next cycle.
    assign used         = 6'(fifo_cnt) + 6'(pipe_cnt) + 6'(iss_vld_q);
    assign io_cmd_ready = (used < 6'(RSP_DEPTH));

    assign io_rsp_valid  = fifo_vld;
    assign io_rsp_result = fifo_dout[FW-1:TAG_W];
    assign io_rsp_tag    = fifo_dout[TAG_W-1:0];
    assign io_busy       = iss_vld_q || (pipe_cnt != '0) || (fifo_cnt != '0);

`ifdef ALU_SELFCHECK_EN
    logic             err_q;
    logic [TAG_W-1:0] err_tag_q;

    // Sticky; keeps the tag of the first mismatching result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q     <= 1'b0;
            err_tag_q <= '0;
        end else if (tail_vld && !err_q && (tail_exp != io_alu_result)) begin
            err_q     <= 1'b1;
            err_tag_q <= tail_tag;
        end
    end

    assign io_err     = err_q;
    assign io_err_tag = err_tag_q;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver with a registered (ALU_LAT=1) ALU model and a
// response scoreboard; covers the ALU_SELFCHECK_EN ports when that macro is set.
module tb_alu_cmd_driver;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             io_cmd_valid, io_cmd_ready;
    logic [2:0]       io_cmd_op;
    logic [15:0]      io_cmd_a, io_cmd_b;
    logic [TAG_W-1:0] io_cmd_tag;
    logic [15:0]      io_alu_a, io_alu_b;
    logic [2:0]       io_alu_aluOp;
    logic [15:0]      io_alu_result;
    logic             io_rsp_valid, io_rsp_ready;
    logic [15:0]      io_rsp_result;
    logic [TAG_W-1:0] io_rsp_tag;
    logic             io_busy;
`ifdef ALU_SELFCHECK_EN
    logic             io_err;
    logic [TAG_W-1:0] io_err_tag;
`endif

    typedef struct packed {
        logic [15:0]      res;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    typedef struct {
        logic [2:0]       op;
        logic [15:0]      a;
        logic [15:0]      b;
        logic [TAG_W-1:0] tag;
        logic [15:0]      exp;
    } vec_t;

    rsp_t sb[$];
    vec_t vt[10];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   rsp_seen = 0;
    int   cyc = 0;
    logic mon_en = 1'b0;
    logic corrupt_en = 1'b0;

    alu_cmd_driver #(.ALU_LAT(1), .RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_cmd_valid  (io_cmd_valid),
        .io_cmd_ready  (io_cmd_ready),
        .io_cmd_op     (io_cmd_op),
        .io_cmd_a      (io_cmd_a),
        .io_cmd_b      (io_cmd_b),
        .io_cmd_tag    (io_cmd_tag),
        .io_alu_a      (io_alu_a),
        .io_alu_b      (io_alu_b),
        .io_alu_aluOp  (io_alu_aluOp),
        .io_alu_result (io_alu_result),
        .io_rsp_valid  (io_rsp_valid),
        .io_rsp_ready  (io_rsp_ready),
        .io_rsp_result (io_rsp_result),
        .io_rsp_tag    (io_rsp_tag),
`ifdef ALU_SELFCHECK_EN
        .io_err        (io_err),
        .io_err_tag    (io_err_tag),
`endif
        .io_busy       (io_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return b;
            3'd7:    return {1'b0, a[15:1]};
            default: return a;
        endcase
    endfunction

    // One-cycle registered ALU; optionally corrupts ADD 12+5.
    always @(posedge clock)
        io_alu_result <= (corrupt_en && io_alu_aluOp == 3'd1 && io_alu_a == 16'd12 && io_alu_b == 16'd5)
                         ? 16'h0000 : ref_alu(io_alu_aluOp, io_alu_a, io_alu_b);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    always @(negedge clock) begin : mon
        rsp_t e;
        if (mon_en && io_rsp_valid && io_rsp_ready) begin
            rsp_seen++;
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL rsp_unexpected: got tag %0d result 0x%0h, expected no response", io_rsp_tag, io_rsp_result);
            end else begin
                e = sb.pop_front();
                chk("rsp_result", {16'd0, io_rsp_result}, {16'd0, e.res});
                chk("rsp_tag", {28'd0, io_rsp_tag}, {28'd0, e.tag});
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Leaves io_cmd_valid high on return so callers can issue back-to-back.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [TAG_W-1:0] tag, input logic [15:0] exp);
        bit   acc;
        int   n;
        rsp_t r;
        acc = 1'b0;
        n   = 0;
        io_cmd_valid = 1'b1;
        io_cmd_op    = op;
        io_cmd_a     = a;
        io_cmd_b     = b;
        io_cmd_tag   = tag;
        while (!acc && n < 100) begin
            @(negedge clock);
            acc = io_cmd_ready;
            tick();
            n++;
        end
        if (acc) begin
            r.res = exp;
            r.tag = tag;
            sb.push_back(r);
        end else begin
            total_cnt++;
            $display("FAIL cmd_accept_timeout: ready low 100 cycles for tag %0d, expected accept", tag);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || io_busy) && n < 200) begin
            tick();
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_alu_op"},  {29'd0, io_alu_aluOp}, 0);
        chk({pfx, "_alu_a"},   {16'd0, io_alu_a}, 0);
        chk({pfx, "_alu_b"},   {16'd0, io_alu_b}, 0);
        chk({pfx, "_rsp_vld"}, {31'd0, io_rsp_valid}, 0);
        chk({pfx, "_rsp_res"}, {16'd0, io_rsp_result}, 0);
        chk({pfx, "_rsp_tag"}, {28'd0, io_rsp_tag}, 0);
        chk({pfx, "_busy"},    {31'd0, io_busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nacc, seen0;
        vt[0] = '{3'd0, 16'd12, 16'd5, 4'd0, 16'd12};
        vt[1] = '{3'd1, 16'd12, 16'd5, 4'd1, 16'd17};
        vt[2] = '{3'd2, 16'd12, 16'd5, 4'd2, 16'd7};
        vt[3] = '{3'd3, 16'd12, 16'd5, 4'd3, 16'd4};
        vt[4] = '{3'd4, 16'd12, 16'd5, 4'd4, 16'd13};
        vt[5] = '{3'd5, 16'd12, 16'd5, 4'd5, 16'd9};
        vt[6] = '{3'd6, 16'd12, 16'd5, 4'd6, 16'd5};
        vt[7] = '{3'd7, 16'd12, 16'd5, 4'd7, 16'd6};
        vt[8] = '{3'd2, 16'h0000, 16'h0001, 4'd8, 16'hFFFF};
        vt[9] = '{3'd1, 16'hFFFF, 16'h0001, 4'd9, 16'h0000};

        io_cmd_valid = 1'b0;
        io_cmd_op    = 3'd0;
        io_cmd_a     = 16'd0;
        io_cmd_b     = 16'd0;
        io_cmd_tag   = '0;
        io_rsp_ready = 1'b0;

        // Reset state
        #2 reset = 1'b0;
        #10;
        chk_outputs_zero("rst");
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_rst", {31'd0, io_cmd_ready}, 1);
        mon_en = 1'b1;
        tick();

        // Single command: two-cycle latency, NOP on idle cycles
        io_rsp_ready = 1'b1;
        chk("idle_op", {29'd0, io_alu_aluOp}, 0);
        send(3'd1, 16'd12, 16'd5, 4'd3, 16'd17);
        io_cmd_valid = 1'b0;
        @(negedge clock);
        chk("single_op_issue", {29'd0, io_alu_aluOp}, 1);
        chk("single_vld_e1", {31'd0, io_rsp_valid}, 0);
        @(negedge clock);
        chk("single_op_after", {29'd0, io_alu_aluOp}, 0);
        chk("single_vld_e2", {31'd0, io_rsp_valid}, 0);
        @(negedge clock);
        chk("single_vld_e3", {31'd0, io_rsp_valid}, 1);
        tick();
        drain("single_drain");

        // Burst of all eight opcodes, one accept per cycle
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);
        io_cmd_valid = 1'b0;
        chk("burst_cycles", cyc - c0, 8);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("burst_stream_vld", {31'd0, io_rsp_valid}, 1);
        end
        @(negedge clock);
        chk("burst_stream_end", {31'd0, io_rsp_valid}, 0);
        tick();
        drain("burst_drain");

        // Backpressure: exactly RSP_DEPTH accepts, ready returns a cycle after first pop
        io_rsp_ready = 1'b0;
        nacc = 0;
        io_cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rsp_t r;
            io_cmd_op  = 3'd1;
            io_cmd_a   = 16'(100 * (nacc + 1));
            io_cmd_b   = 16'(nacc);
            io_cmd_tag = 4'(8 + nacc);
            @(negedge clock);
            if (io_cmd_ready) begin
                r.res = ref_alu(io_cmd_op, io_cmd_a, io_cmd_b);
                r.tag = io_cmd_tag;
                sb.push_back(r);
                nacc++;
            end
            tick();
        end
        io_cmd_valid = 1'b0;
        chk("bp_accepts", nacc, 4);
        @(negedge clock);
        chk("bp_ready_low", {31'd0, io_cmd_ready}, 0);
        chk("bp_busy", {31'd0, io_busy}, 1);
        chk("bp_head_vld", {31'd0, io_rsp_valid}, 1);
        chk("bp_head_tag", {28'd0, io_rsp_tag}, 8);
        chk("bp_head_hold", {16'd0, io_rsp_result}, {16'd0, sb[0].res});
        tick();
        io_rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_ready_same_cyc", {31'd0, io_cmd_ready}, 0);
        @(negedge clock);
        chk("bp_ready_next_cyc", {31'd0, io_cmd_ready}, 1);
        tick();
        drain("bp_drain");

        // Reset with two in flight and one buffered
        io_rsp_ready = 1'b0;
        send(3'd1, 16'h1111, 16'h0001, 4'd1, 16'h1112);
        send(3'd4, 16'h2222, 16'h0100, 4'd2, 16'h2322);
        send(3'd5, 16'h3333, 16'h00FF, 4'd3, 16'h33CC);
        io_cmd_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        sb.delete();
        tick();
        reset = 1'b1;
        tick();
        io_rsp_ready = 1'b1;
        seen0 = rsp_seen;
        send(3'd5, 16'hA5A5, 16'h0F0F, 4'd9, 16'hAAAA);
        io_cmd_valid = 1'b0;
        repeat (6) tick();
        drain("midrst_drain");
        chk("midrst_rsp_count", rsp_seen - seen0, 1);

        // Wrap boundaries, then alternating rsp_ready over a pointer wrap
        for (int i = 8; i < 10; i++) send(vt[i].op, vt[i].a, vt[i].b, vt[i].tag, vt[i].exp);
        io_cmd_valid = 1'b0;
        drain("wrap_drain");
        seen0 = rsp_seen;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [2:0]  op;
                    logic [15:0] a, b;
                    op = 3'($urandom_range(0, 7));
                    a  = 16'($urandom);
                    b  = 16'($urandom);
                    send(op, a, b, 4'(i), ref_alu(op, a, b));
                end
                io_cmd_valid = 1'b0;
            end
            begin
                repeat (30) begin
                    tick();
                    io_rsp_ready = ~io_rsp_ready;
                end
            end
        join
        io_rsp_ready = 1'b1;
        drain("alt_drain");
        chk("alt_rsp_count", rsp_seen - seen0, 10);

`ifdef ALU_SELFCHECK_EN
        chk("err_clear", {31'd0, io_err}, 0);
        corrupt_en = 1'b1;
        send(3'd1, 16'd12, 16'd5, 4'd5, 16'h0000);
        io_cmd_valid = 1'b0;
        drain("err_drain");
        corrupt_en = 1'b0;
        chk("err_set", {31'd0, io_err}, 1);
        chk("err_tag", {28'd0, io_err_tag}, 5);
        send(3'd2, 16'd12, 16'd5, 4'd6, 16'd7);
        io_cmd_valid = 1'b0;
        drain("err_drain2");
        chk("err_sticky", {31'd0, io_err}, 1);
        chk("err_tag_sticky", {28'd0, io_err_tag}, 5);
        reset = 1'b0;
        #1;
        chk("err_rst", {31'd0, io_err}, 0);
        tick();
        reset = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
